// File: rtl/gps_pkg.sv
// Shared definitions for the GPS trip accumulator: widths, FSM states,
// report record layout and a saturating counter helper.
// Optional feature macro: GPS_TRIP_AVG_EN (adds the DIV state).
package gps_pkg;

  localparam int D_W   = 40;
  localparam int SUM_W = 48;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
`ifdef GPS_TRIP_AVG_EN
    , ST_DIV  = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [SUM_W-1:0] total;
    logic [CNT_W-1:0] segs;
    logic [CNT_W-1:0] rej;
    logic [D_W-1:0]   longest;
    logic [D_W-1:0]   avg;
  } rpt_rec_t;

  localparam int REC_W = $bits(rpt_rec_t);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gps_rpt_fifo.sv
// First-word-fall-through report FIFO: head is visible on rd_data while
// rd_valid is high; a push while full is accepted only alongside a pop.
module gps_rpt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop, wr_en;

  assign rd_valid = (count_reg != '0);
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = push && (!full || pop);
  // Gate the head so an empty FIFO presents an all-zero record.
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gps_trip_accum.sv
// Trip statistics accumulator: sums accepted segment distances, counts
// accepted and rejected (jump) segments, tracks the longest segment and
// queues one report record per trip into a small FWFT FIFO.
// Optional feature macro: GPS_TRIP_AVG_EN (restoring divider for rpt_avg).
module gps_trip_accum
  import gps_pkg::*;
#(
  parameter logic [D_W-1:0] JUMP_TH    = 40'h00_0010_0000,
  parameter int             FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trip_start,
  input  logic             trip_end,
  input  logic             dist_valid,
  input  logic [D_W-1:0]   dist_in,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [SUM_W-1:0] rpt_total,
  output logic [CNT_W-1:0] rpt_segs,
  output logic [CNT_W-1:0] rpt_rej,
  output logic [D_W-1:0]   rpt_max,
  output logic [D_W-1:0]   rpt_avg,
  output logic             fifo_full
);

  state_t           state_reg, state_next;
  logic [SUM_W-1:0] total_reg;
  logic [CNT_W-1:0] segs_reg, rej_reg;
  logic [D_W-1:0]   max_reg;
  logic             clear_stats, take_dist, push;
  logic [SUM_W:0]   sum_ext;
  logic [D_W-1:0]   avg;
  rpt_rec_t         push_rec, head_rec;

`ifdef GPS_TRIP_AVG_EN
  localparam int DCNT_W = $clog2(SUM_W);
  logic              div_start;
  logic [CNT_W-1:0]  rem_reg;
  logic [SUM_W-1:0]  quot_reg;
  logic [DCNT_W-1:0] div_cnt_reg, bit_idx;
  logic [CNT_W:0]    rem_shift, rem_sub;
  logic              q_bit;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state and control strobes; trip_end takes priority over restart.
  always_comb begin
    state_next  = state_reg;
    clear_stats = 1'b0;
    take_dist   = 1'b0;
    push        = 1'b0;
`ifdef GPS_TRIP_AVG_EN
    div_start   = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (trip_start) begin
          clear_stats = 1'b1;
          state_next  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (trip_end) begin
          take_dist  = dist_valid;
`ifdef GPS_TRIP_AVG_EN
          div_start  = 1'b1;
          state_next = ST_DIV;
`else
          state_next = ST_REPORT;
`endif
        end else if (trip_start) begin
          clear_stats = 1'b1;
        end else begin
          take_dist = dist_valid;
        end
      end
      ST_REPORT: begin
        if (!fifo_full) begin
          push       = 1'b1;
          state_next = ST_IDLE;
        end
      end
`ifdef GPS_TRIP_AVG_EN
      ST_DIV: begin
        if (segs_reg == '0 || div_cnt_reg == DCNT_W'(SUM_W - 1))
          state_next = ST_REPORT;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign sum_ext = {1'b0, total_reg} + {{(SUM_W + 1 - D_W){1'b0}}, dist_in};

  // Statistics update: jumps only bump the reject counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_reg <= '0;
      segs_reg  <= '0;
      rej_reg   <= '0;
      max_reg   <= '0;
    end else if (clear_stats) begin
      total_reg <= '0;
      segs_reg  <= '0;
      rej_reg   <= '0;
      max_reg   <= '0;
    end else if (take_dist) begin
      if (dist_in > JUMP_TH) begin
        rej_reg <= sat_inc(rej_reg);
      end else begin
        total_reg <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        segs_reg  <= sat_inc(segs_reg);
        if (dist_in > max_reg) max_reg <= dist_in;
      end
    end
  end

`ifdef GPS_TRIP_AVG_EN
  // One restoring step per cycle, consuming the total MSB first.
  assign bit_idx   = DCNT_W'(SUM_W - 1) - div_cnt_reg;
  assign rem_shift = {rem_reg, total_reg[bit_idx]};
  assign rem_sub   = rem_shift - {1'b0, segs_reg};
  assign q_bit     = (rem_shift >= {1'b0, segs_reg});

  // Divider registers; cleared when the trip closes, stepped while in DIV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_reg     <= '0;
      quot_reg    <= '0;
      div_cnt_reg <= '0;
    end else if (div_start) begin
      rem_reg     <= '0;
      quot_reg    <= '0;
      div_cnt_reg <= '0;
    end else if (state_reg == ST_DIV && segs_reg != '0) begin
      rem_reg     <= q_bit ? rem_sub[CNT_W-1:0] : rem_shift[CNT_W-1:0];
      quot_reg    <= {quot_reg[SUM_W-2:0], q_bit};
      div_cnt_reg <= div_cnt_reg + DCNT_W'(1);
    end
  end

  assign avg = (|quot_reg[SUM_W-1:D_W]) ? '1 : quot_reg[D_W-1:0];
`else
  assign avg = '0;
`endif

  assign push_rec = '{total: total_reg, segs: segs_reg, rej: rej_reg,
                      longest: max_reg, avg: avg};

  gps_rpt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .wr_data  (push_rec),
    .rd_ready (rpt_ready),
    .rd_valid (rpt_valid),
    .rd_data  (head_rec),
    .full     (fifo_full)
  );

  assign busy      = (state_reg != ST_IDLE);
  assign rpt_total = head_rec.total;
  assign rpt_segs  = head_rec.segs;
  assign rpt_rej   = head_rec.rej;
  assign rpt_max   = head_rec.longest;
  assign rpt_avg   = head_rec.avg;

endmodule

// File: tb/tb_gps_trip_accum.sv
// Self-checking bench for gps_trip_accum: table of directed trips, FIFO
// full/drain, saturation, async reset and randomized trips against a model.
module tb_gps_trip_accum;
  import gps_pkg::*;

  localparam logic [D_W-1:0]   JTH  = 40'h00_0010_0000;
  localparam logic [SUM_W-1:0] MAXT = '1;

  typedef struct packed {
    logic [SUM_W-1:0] total;
    logic [CNT_W-1:0] segs;
    logic [CNT_W-1:0] rej;
    logic [D_W-1:0]   longest;
    logic [D_W-1:0]   avg;
  } exp_t;

  typedef struct packed {
    logic [2:0]       n;
    logic [D_W-1:0]   d0, d1, d2;
    logic             end_v;
    logic [D_W-1:0]   end_d;
    logic [SUM_W-1:0] total;
    logic [CNT_W-1:0] segs;
    logic [CNT_W-1:0] rej;
    logic [D_W-1:0]   longest;
  } vec_t;

  logic clk = 0, reset_n = 1, trip_start = 0, trip_end = 0, dist_valid = 0;
  logic [D_W-1:0] dist_in = '0;
  logic rpt_ready = 1, sat_ready = 1;
  logic busy, rpt_valid, fifo_full;
  logic [SUM_W-1:0] rpt_total;
  logic [CNT_W-1:0] rpt_segs, rpt_rej;
  logic [D_W-1:0] rpt_max, rpt_avg;
  logic s_busy, s_valid, s_full;
  logic [SUM_W-1:0] s_total;
  logic [CNT_W-1:0] s_segs, s_rej;
  logic [D_W-1:0] s_max, s_avg;

  int checks = 0, errors = 0;
  bit rand_ready = 0;
  exp_t exp_q[$];
  vec_t vecs[5];

  // Reference statistics for the current trip.
  longint m_total;
  int m_segs, m_rej;
  logic [D_W-1:0] m_max;

  always #5 clk = ~clk;

  gps_trip_accum #(.JUMP_TH(JTH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .trip_start(trip_start), .trip_end(trip_end),
    .dist_valid(dist_valid), .dist_in(dist_in), .busy(busy), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_total(rpt_total), .rpt_segs(rpt_segs),
    .rpt_rej(rpt_rej), .rpt_max(rpt_max), .rpt_avg(rpt_avg), .fifo_full(fifo_full));

  // Second instance with no effective jump threshold, used to reach total saturation.
  gps_trip_accum #(.JUMP_TH(40'hFF_FFFF_FFFF), .FIFO_DEPTH(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .trip_start(trip_start), .trip_end(trip_end),
    .dist_valid(dist_valid), .dist_in(dist_in), .busy(s_busy), .rpt_valid(s_valid),
    .rpt_ready(sat_ready), .rpt_total(s_total), .rpt_segs(s_segs),
    .rpt_rej(s_rej), .rpt_max(s_max), .rpt_avg(s_avg), .fifo_full(s_full));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [D_W-1:0] calc_avg(input logic [SUM_W-1:0] t, input logic [CNT_W-1:0] s);
`ifdef GPS_TRIP_AVG_EN
    logic [SUM_W-1:0] q;
    if (s == 0) return '0;
    q = t / s;
    return (q > {{(SUM_W-D_W){1'b0}}, {D_W{1'b1}}}) ? '1 : q[D_W-1:0];
`else
    return '0 + (t & 0) + (s & 0);
`endif
  endfunction

  function automatic int exp_latency(input int segs);
`ifdef GPS_TRIP_AVG_EN
    return (segs == 0) ? 3 : 2 + SUM_W;
`else
    return 2 + (segs & 0);
`endif
  endfunction

  task automatic m_clear();
    m_total = 0; m_segs = 0; m_rej = 0; m_max = '0;
  endtask

  task automatic m_apply(input logic [D_W-1:0] d);
    if (d > JTH) begin
      if (m_rej < 65535) m_rej++;
    end else begin
      m_total = m_total + longint'(d);
      if (m_total > longint'(MAXT)) m_total = longint'(MAXT);
      if (m_segs < 65535) m_segs++;
      if (d > m_max) m_max = d;
    end
  endtask

  task automatic m_push();
    exp_t e;
    e.total = m_total[SUM_W-1:0];
    e.segs = CNT_W'(m_segs);
    e.rej = CNT_W'(m_rej);
    e.longest = m_max;
    e.avg = calc_avg(e.total, e.segs);
    exp_q.push_back(e);
  endtask

  // Advance one cycle; a record popped at this edge is checked first.
  task automatic tick();
    exp_t e;
    if (reset_n && rpt_valid && rpt_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected: got total=%0d expected no record", rpt_total);
      end else begin
        e = exp_q.pop_front();
        $display("pop total=%0d segs=%0d rej=%0d max=%0d avg=%0d",
                 rpt_total, rpt_segs, rpt_rej, rpt_max, rpt_avg);
        chk("rec_total", 64'(rpt_total), 64'(e.total));
        chk("rec_segs", 64'(rpt_segs), 64'(e.segs));
        chk("rec_rej", 64'(rpt_rej), 64'(e.rej));
        chk("rec_max", 64'(rpt_max), 64'(e.longest));
        chk("rec_avg", 64'(rpt_avg), 64'(e.avg));
      end
    end
    @(posedge clk); #1;
    if (rand_ready) rpt_ready = 1'($urandom % 2);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_valid"}, 64'(rpt_valid), 0);
    chk({nm, "_full"}, 64'(fifo_full), 0);
    chk({nm, "_total"}, 64'(rpt_total), 0);
    chk({nm, "_segs"}, 64'(rpt_segs), 0);
    chk({nm, "_rej"}, 64'(rpt_rej), 0);
    chk({nm, "_max"}, 64'(rpt_max), 0);
    chk({nm, "_avg"}, 64'(rpt_avg), 0);
  endtask

  task automatic do_reset();
    reset_n = 0; trip_start = 0; trip_end = 0; dist_valid = 0;
    tick(); tick();
    reset_n = 1;
    exp_q.delete();
    tick();
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin tick(); k++; end
    chk(nm, 64'(busy), 0);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin tick(); k++; end
    chk(nm, 64'(exp_q.size()), 0);
  endtask

  function automatic logic [D_W-1:0] rand_dist();
    logic [63:0] r;
    case ($urandom % 4)
      0: return D_W'($urandom_range(0, 5000));
      1: return JTH;
      2: return JTH + D_W'(1 + ($urandom % 8));
      default: begin r = {$urandom, $urandom}; return r[D_W-1:0]; end
    endcase
  endfunction

  // Simple trip whose accepted segments come from the model.
  task automatic model_trip(input int len);
    m_clear();
    trip_start = 1; tick(); trip_start = 0;
    for (int i = 0; i < len; i++) begin
      dist_valid = 1; dist_in = D_W'($urandom_range(1, 1000)); m_apply(dist_in); tick();
    end
    dist_valid = 0;
    m_push();
    trip_end = 1; tick(); trip_end = 0;
  endtask

  function automatic vec_t mk(input int n, input logic [D_W-1:0] a, b, c,
                              input logic ev, input logic [D_W-1:0] ed,
                              input logic [SUM_W-1:0] t, input int s, r,
                              input logic [D_W-1:0] mx);
    vec_t v;
    v.n = 3'(n); v.d0 = a; v.d1 = b; v.d2 = c; v.end_v = ev; v.end_d = ed;
    v.total = t; v.segs = CNT_W'(s); v.rej = CNT_W'(r); v.longest = mx;
    return v;
  endfunction

  initial begin
    vec_t v;
    exp_t e;
    logic [D_W-1:0] dv [3];
    int lat, len;

    vecs[0] = mk(3, 100, 200, 50, 0, 0, 350, 3, 0, 200);
    vecs[1] = mk(2, JTH + 1, JTH, 0, 0, 0, SUM_W'(JTH), 1, 1, JTH);
    vecs[2] = mk(1, 100, 0, 0, 1, 300, 400, 2, 0, 300);
    vecs[3] = mk(3, 10, 20, 31, 0, 0, 61, 3, 0, 31);
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    #2 reset_n = 0;
    #1 check_zero("reset");
    do_reset();

    // Directed table: record contents and trip_end-to-rpt_valid latency.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      dv[0] = v.d0; dv[1] = v.d1; dv[2] = v.d2;
      e.total = v.total; e.segs = v.segs; e.rej = v.rej; e.longest = v.longest;
      e.avg = calc_avg(v.total, v.segs);
      exp_q.push_back(e);
      trip_start = 1; tick(); trip_start = 0;
      for (int k = 0; k < int'(v.n); k++) begin
        dist_valid = 1; dist_in = dv[k]; tick();
      end
      trip_end = 1; dist_valid = v.end_v; dist_in = v.end_d; tick();
      trip_end = 0; dist_valid = 0;
      lat = 1;
      while (!rpt_valid && lat < 200) begin tick(); lat++; end
      chk($sformatf("latency_vec%0d", i), 64'(lat), 64'(exp_latency(int'(v.segs))));
      tick(); tick();
      chk($sformatf("drained_vec%0d", i), 64'(exp_q.size()), 0);
    end

    // FIFO full: four stored records, fifth trip held in REPORT.
    rpt_ready = 0;
    for (int i = 0; i < 4; i++) begin model_trip(i + 1); wait_idle("full_fill_idle"); end
    chk("full_flag", 64'(fifo_full), 1);
    chk("full_valid", 64'(rpt_valid), 1);
    chk("fwft_head", 64'(rpt_total), 64'(exp_q[0].total));
    model_trip(5);
    tick(); tick(); tick();
    chk("full_busy_hold", 64'(busy), 1);
    chk("full_flag_hold", 64'(fifo_full), 1);
    rpt_ready = 1;
    wait_idle("full_release_idle");
    wait_drain("full_drain");

    // Total saturation on the wide-threshold instance; main DUT rejects them all.
    sat_ready = 0;
    m_clear();
    trip_start = 1; tick(); trip_start = 0;
    for (int i = 0; i < 260; i++) begin
      dist_valid = 1; dist_in = 40'hFF_FFFF_FFFF; m_apply(dist_in); tick();
    end
    dist_valid = 0;
    m_push();
    trip_end = 1; tick(); trip_end = 0;
    wait_idle("sat_idle");
    tick(); tick();
    chk("sat_valid", 64'(s_valid), 1);
    chk("sat_total", 64'(s_total), 64'(MAXT));
    chk("sat_segs", 64'(s_segs), 260);
    chk("sat_max", 64'(s_max), 64'h00FF_FFFF_FFFF);
    sat_ready = 1;
    wait_drain("sat_drain");

    // Asynchronous reset mid-trip with one record queued.
    rpt_ready = 0;
    model_trip(2); wait_idle("rst1_idle");
    trip_start = 1; tick(); trip_start = 0;
    dist_valid = 1; dist_in = 77; tick(); dist_valid = 0;
    reset_n = 0; exp_q.delete();
    #1 check_zero("rst_accum");
    tick(); reset_n = 1; tick();
    check_zero("rst_accum_after");

    // Asynchronous reset while in REPORT with the FIFO partly full.
    model_trip(1); wait_idle("rst2_idle_a");
    model_trip(2); wait_idle("rst2_idle_b");
    model_trip(3);
    chk("rst_report_busy", 64'(busy), 1);
    reset_n = 0; exp_q.delete();
    #1 check_zero("rst_report");
    tick(); reset_n = 1; tick();
    check_zero("rst_report_after");
    rpt_ready = 1;

    // Randomized trips with restarts, combined start/end and random ready.
    rand_ready = 1;
    for (int t = 0; t < 30; t++) begin
      m_clear();
      trip_start = 1; tick(); trip_start = 0;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom % 16 == 0) begin
          trip_start = 1; m_clear();
        end else begin
          dist_valid = 1'($urandom % 2); dist_in = rand_dist();
          if (dist_valid) m_apply(dist_in);
        end
        tick(); trip_start = 0; dist_valid = 0;
      end
      trip_end = 1; trip_start = ($urandom % 4 == 0);
      dist_valid = 1'($urandom % 2); dist_in = rand_dist();
      if (dist_valid) m_apply(dist_in);
      m_push();
      tick(); trip_end = 0; trip_start = 0; dist_valid = 0;
      wait_idle("rand_idle");
    end
    rand_ready = 0; rpt_ready = 1;
    wait_drain("rand_drain");
    chk("final_empty", 64'(rpt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
